pll_lock_reset_sequencer: RTL

- Sits directly downstream of the board PLL wrapper and runs in the PLL output clock domain.
- Takes the PLL's raw lock indication and produces a clean, synchronous, stretched reset for the logic clocked by the PLL output.
- Produces a phase-aligned clock-enable strobe at 1/CE_DIV of the PLL clock, used as the pixel-rate enable next to a 5x serializer clock.
- Counts lock-loss events for debug display on LEDs or seven-segment.

---
 rtl/pll_lock_reset_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pll_lock_reset_sequencer.sv
// Turns a raw PLL lock into a qualified, stretched synchronous reset, a phase-aligned
// clock-enable strobe for the pixel domain, and a saturating lock-loss event counter.
module pll_lock_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned CE_DIV             = 5,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_async,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  ce,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int unsigned MAX_LIMIT = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                      LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_LIMIT) + 1;
  localparam int unsigned CE_W      = $clog2(CE_DIV);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(RESET_HOLD_CYCLES);
  localparam logic [CE_W-1:0]  CE_LAST    = CE_W'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CE_W-1:0]         ce_cnt_q, ce_cnt_d;
  logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic                    rst_out_q, rst_out_d;
  logic                    ready_q, ready_d;
  logic                    ce_q, ce_d;
  logic                    lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state, counters and registered output decode.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], lock_async};
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_cnt_d = loss_cnt_q;
    ce_cnt_d   = '0;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LIM) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LIM) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Divider phase restarts at 0 on every entry into RUN so ce lines up with ready.
    if ((state_q == RUN) && (state_d == RUN)) begin
      ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CE_W'(1);
    end

    rst_out_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    ce_d      = (state_d == RUN) && (ce_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      ce_cnt_q   <= '0;
      loss_cnt_q <= '0;
      rst_out_q  <= 1'b1;
      ready_q    <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ce_cnt_q   <= ce_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      ce_q       <= ce_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign ready    = ready_q;
  assign ce       = ce_q;
  assign loss_cnt = loss_cnt_q;

endmodule
